// File: rtl/ha_result_accumulator.sv
// Synchronises the half-adder sum/carry and a strobe pin, accepts one sample per debounced
// strobe press, and accumulates carry*2+sum into a wrapping total with sticky ovf/err flags.
module ha_result_accumulator #(
  parameter int ACC_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCKOUT     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             strobe_in,
  input  logic             sum_in,
  input  logic             carry_in,
  input  logic             clear_in,
  output logic [ACC_W-1:0] acc_out,
  output logic [3:0]       sample_cnt,
  output logic             ovf,
  output logic             err,
  output logic             valid_pulse
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  localparam logic [3:0] LOCK_LAST = 4'(LOCKOUT - 1);

  logic [SYNC_STAGES-1:0] r_sync_stb, r_sync_sum, r_sync_cry;
  logic                   r_stb_prev;
  state_t                 r_state, w_state_nxt;
  logic [3:0]             r_lock_cnt, w_lock_cnt_nxt;
  logic                   w_accept;
  logic [ACC_W-1:0]       r_acc;
  logic [3:0]             r_cnt;
  logic                   r_ovf, r_err, r_valid;

  logic                   w_stb_s, w_sum_s, w_cry_s, w_edge;
  logic [ACC_W:0]         w_acc_sum;

  // Operands share the strobe's pipeline depth so they arrive aligned with the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync_stb <= '0;
      r_sync_sum <= '0;
      r_sync_cry <= '0;
    end else begin
      r_sync_stb <= {r_sync_stb[SYNC_STAGES-2:0], strobe_in};
      r_sync_sum <= {r_sync_sum[SYNC_STAGES-2:0], sum_in};
      r_sync_cry <= {r_sync_cry[SYNC_STAGES-2:0], carry_in};
    end
  end

  assign w_stb_s   = r_sync_stb[SYNC_STAGES-1];
  assign w_sum_s   = r_sync_sum[SYNC_STAGES-1];
  assign w_cry_s   = r_sync_cry[SYNC_STAGES-1];
  assign w_edge    = w_stb_s & ~r_stb_prev;
  assign w_acc_sum = {1'b0, r_acc} + {{(ACC_W-1){1'b0}}, w_cry_s, w_sum_s};

  always_comb begin
    w_state_nxt    = r_state;
    w_lock_cnt_nxt = r_lock_cnt;
    w_accept       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_edge) begin
          w_accept       = 1'b1;
          w_state_nxt    = S_HOLD;
          w_lock_cnt_nxt = 4'd0;
        end
      end
      S_HOLD: begin
        // Re-arm only after LOCKOUT consecutive low cycles; any high restarts the count.
        if (w_stb_s) begin
          w_lock_cnt_nxt = 4'd0;
        end else if (r_lock_cnt == LOCK_LAST) begin
          w_state_nxt    = S_IDLE;
          w_lock_cnt_nxt = 4'd0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_lock_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stb_prev <= 1'b0;
      r_state    <= S_IDLE;
      r_lock_cnt <= 4'd0;
    end else if (ena) begin
      r_stb_prev <= w_stb_s;
      r_state    <= w_state_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= 4'd0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (!ena) begin
      r_valid <= 1'b0;
    end else if (clear_in) begin
      r_acc   <= '0;
      r_cnt   <= 4'd0;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_acc   <= w_acc_sum[ACC_W-1:0];
      r_ovf   <= r_ovf | w_acc_sum[ACC_W];
      r_err   <= r_err | (w_sum_s & w_cry_s);
      r_valid <= 1'b1;
      if (r_cnt != 4'hF) begin
        r_cnt <= r_cnt + 4'd1;
      end
    end else begin
      r_valid <= 1'b0;
    end
  end

  assign acc_out     = r_acc;
  assign sample_cnt  = r_cnt;
  assign ovf         = r_ovf;
  assign err         = r_err;
  assign valid_pulse = r_valid;

endmodule
